// File: rtl/psram_word_bridge_if.sv
// CPU-side word bus of the PSRAM word bridge: single-cycle rd/we requests in,
// completion pulse, status and read data out.
interface psram_word_bridge_if;
  logic [23:0] a;
  logic [31:0] d;
  logic        rd;
  logic        we;
  logic [31:0] spo;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output a, d, rd, we,
    input  spo, ready, busy, err
  );

  modport slave (
    input  a, d, rd, we,
    output spo, ready, busy, err
  );
endinterface

// File: rtl/psram_word_bridge.sv
// Word-to-byte-stream bridge in front of the QPI PSRAM controller. Turns one CPU
// word request into the controller's rd/rend or we/wend byte handshake, packs or
// unpacks NBYTES little-endian bytes and returns a one-cycle ready pulse.
module psram_word_bridge #(
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  psram_word_bridge_if.slave   bus,
  output logic [23:0]          mem_a,
  output logic                 mem_rd,
  output logic                 mem_rend,
  output logic                 mem_we,
  output logic                 mem_wend,
  output logic [7:0]           mem_din,
  input  logic [7:0]           mem_dout,
  input  logic                 mem_byte_available,
  input  logic                 mem_ready_for_next_byte,
  input  logic                 mem_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWIssue,
    StWStream,
    StRIssue,
    StRStream,
    StDrain,
    StDone
  } state_e;

  state_e        r_state;
  logic [31:0]   r_wdata;
  logic [31:0]   r_spo;
  logic [23:0]   r_mem_a;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_rfnb_q;
  logic          r_bav_q;
  logic          r_seen_busy;
  logic          r_ready;
  logic          r_busy;
  logic          r_err;
  logic          r_mem_rd;
  logic          r_mem_rend;
  logic          r_mem_we;
  logic          r_mem_wend;

  logic          w_rfnb_fall;
  logic          w_bav_rise;
  logic          w_tmo_hit;
  logic          w_last;

  // The controller samples din while rfnb is high, so a falling edge means consumed.
  assign w_rfnb_fall = r_rfnb_q & ~mem_ready_for_next_byte;
  assign w_bav_rise  = ~r_bav_q & mem_byte_available;
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_last      = (r_idx == 3'(NBYTES - 1));

  // Registered copies of the controller strobes for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rfnb_q <= 1'b0;
      r_bav_q  <= 1'b0;
    end else begin
      r_rfnb_q <= mem_ready_for_next_byte;
      r_bav_q  <= mem_byte_available;
    end
  end

  // Transaction FSM with all outputs registered; timeout beats any byte event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wdata     <= '0;
      r_spo       <= '0;
      r_mem_a     <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_seen_busy <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_rend  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wend  <= 1'b0;
    end else begin
      r_mem_rd   <= 1'b0;
      r_mem_rend <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_wend <= 1'b0;
      r_ready    <= 1'b0;

      if (r_state != StIdle) begin
        r_tmo <= r_tmo + 1'b1;
        // Controller drops mem_ready shortly after issue; a high level alone
        // only means completion once a low has been observed.
        if (!mem_ready) r_seen_busy <= 1'b1;
      end

      if (r_state != StIdle && r_state != StDone && w_tmo_hit) begin
        r_err   <= 1'b1;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
        r_tmo   <= '0;
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (mem_ready && (bus.we || bus.rd)) begin
              r_mem_a     <= bus.a;
              r_idx       <= '0;
              r_tmo       <= '0;
              r_seen_busy <= 1'b0;
              r_err       <= 1'b0;
              r_busy      <= 1'b1;
              if (bus.we) begin
                r_wdata  <= bus.d;
                r_mem_we <= 1'b1;
                r_state  <= StWIssue;
              end else begin
                r_spo    <= '0;
                r_mem_rd <= 1'b1;
                r_state  <= StRIssue;
              end
            end
          end
          StWIssue: r_state <= StWStream;
          StWStream: begin
            if (w_rfnb_fall) begin
              r_idx   <= r_idx + 1'b1;
              r_wdata <= r_wdata >> 8;
              if (w_last) begin
                r_mem_wend <= 1'b1;
                r_state    <= StDrain;
              end
            end
          end
          StRIssue: r_state <= StRStream;
          StRStream: begin
            if (w_bav_rise) begin
              r_spo[{r_idx[1:0], 3'b000} +: 8] <= mem_dout;
              r_idx <= r_idx + 1'b1;
              if (w_last) begin
                r_mem_rend <= 1'b1;
                r_state    <= StDrain;
              end
            end
          end
          StDrain: begin
            if (r_seen_busy && mem_ready) begin
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.spo   = r_spo;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;
  assign mem_a     = r_mem_a;
  assign mem_rd    = r_mem_rd;
  assign mem_rend  = r_mem_rend;
  assign mem_we    = r_mem_we;
  assign mem_wend  = r_mem_wend;
  // Byte currently offered to the controller; shifted down as bytes are consumed.
  assign mem_din   = r_wdata[7:0];

endmodule

// File: tb/tb_psram_word_bridge.sv
// Directed bench: two bridges (4-byte and 1-byte) share one behavioural PSRAM
// controller model selected by sel; expectations are hand-computed constants.
module tb_psram_word_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic m_stall = 1'b0;

  always #5 clk = ~clk;

  psram_word_bridge_if bus4 ();
  psram_word_bridge_if bus1 ();

  logic [23:0] mem_a4, mem_a1;
  logic        mem_rd4, mem_rend4, mem_we4, mem_wend4;
  logic        mem_rd1, mem_rend1, mem_we1, mem_wend1;
  logic [7:0]  mem_din4, mem_din1;

  // Controller model outputs, shared by both bridges.
  logic        m_ready;
  logic        m_rfnb;
  logic        m_bav;
  logic [7:0]  m_dout;

  psram_word_bridge #(.NBYTES(4), .TIMEOUT(64)) u_dut4 (
    .clk                     (clk),
    .rst                     (rst),
    .bus                     (bus4),
    .mem_a                   (mem_a4),
    .mem_rd                  (mem_rd4),
    .mem_rend                (mem_rend4),
    .mem_we                  (mem_we4),
    .mem_wend                (mem_wend4),
    .mem_din                 (mem_din4),
    .mem_dout                (m_dout),
    .mem_byte_available      (m_bav),
    .mem_ready_for_next_byte (m_rfnb),
    .mem_ready               (m_ready)
  );

  psram_word_bridge #(.NBYTES(1), .TIMEOUT(64)) u_dut1 (
    .clk                     (clk),
    .rst                     (rst),
    .bus                     (bus1),
    .mem_a                   (mem_a1),
    .mem_rd                  (mem_rd1),
    .mem_rend                (mem_rend1),
    .mem_we                  (mem_we1),
    .mem_wend                (mem_wend1),
    .mem_din                 (mem_din1),
    .mem_dout                (m_dout),
    .mem_byte_available      (m_bav),
    .mem_ready_for_next_byte (m_rfnb),
    .mem_ready               (m_ready)
  );

  // Signals of the currently selected bridge.
  logic [23:0] w_mema;
  logic [7:0]  w_din;
  logic [31:0] w_spo;
  logic        w_rd, w_rend, w_we, w_wend, w_ready, w_busy, w_err;

  assign w_mema  = sel ? mem_a1    : mem_a4;
  assign w_din   = sel ? mem_din1  : mem_din4;
  assign w_rd    = sel ? mem_rd1   : mem_rd4;
  assign w_rend  = sel ? mem_rend1 : mem_rend4;
  assign w_we    = sel ? mem_we1   : mem_we4;
  assign w_wend  = sel ? mem_wend1 : mem_wend4;
  assign w_spo   = sel ? bus1.spo   : bus4.spo;
  assign w_ready = sel ? bus1.ready : bus4.ready;
  assign w_busy  = sel ? bus1.busy  : bus4.busy;
  assign w_err   = sel ? bus1.err   : bus4.err;

  // ---------------- controller model ----------------
  typedef enum logic [2:0] {MIdle, MPre, MWHi, MWLo, MRLo, MRHi, MPost} mst_e;

  mst_e       m_st;
  logic [7:0] mem [0:255];
  logic [7:0] m_addr;
  logic [7:0] m_k;
  logic [2:0] m_cnt;
  logic       m_wr;
  int         n_fall = 0;
  int         n_rise = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st    <= MIdle;
      m_ready <= 1'b1;
      m_rfnb  <= 1'b0;
      m_bav   <= 1'b0;
      m_dout  <= 8'h00;
      m_addr  <= 8'h00;
      m_k     <= 8'h00;
      m_cnt   <= 3'd0;
      m_wr    <= 1'b0;
    end else begin
      if (m_st != MIdle && m_st != MPost && (w_wend || w_rend)) begin
        m_rfnb <= 1'b0;
        m_bav  <= 1'b0;
        m_cnt  <= 3'd3;
        m_st   <= MPost;
      end else if (m_stall && m_st != MIdle && !w_busy) begin
        m_ready <= 1'b1;
        m_st    <= MIdle;
      end else begin
        case (m_st)
          MIdle: begin
            if (w_we || w_rd) begin
              m_addr <= w_mema[7:0];
              m_wr   <= w_we;
              m_k    <= 8'h00;
              m_st   <= MPre;
            end
          end
          MPre: begin
            m_ready <= 1'b0;
            if (m_wr) begin
              m_rfnb <= 1'b1;
              m_cnt  <= 3'd1;
              m_st   <= MWHi;
            end else begin
              m_cnt <= 3'd2;
              m_st  <= MRLo;
            end
          end
          MWHi: begin
            if (m_cnt == 3'd0) begin
              mem[m_addr + m_k] <= w_din;
              m_rfnb <= 1'b0;
              n_fall <= n_fall + 1;
              m_cnt  <= 3'd2;
              m_st   <= MWLo;
            end else m_cnt <= m_cnt - 3'd1;
          end
          MWLo: begin
            if (m_cnt == 3'd0) begin
              m_k    <= m_k + 8'd1;
              m_rfnb <= 1'b1;
              m_cnt  <= 3'd1;
              m_st   <= MWHi;
            end else m_cnt <= m_cnt - 3'd1;
          end
          MRLo: begin
            if (m_cnt == 3'd0) begin
              if (!m_stall) begin
                m_dout <= mem[m_addr + m_k];
                m_bav  <= 1'b1;
                n_rise <= n_rise + 1;
                m_cnt  <= 3'd1;
                m_st   <= MRHi;
              end
            end else m_cnt <= m_cnt - 3'd1;
          end
          MRHi: begin
            if (m_cnt == 3'd0) begin
              m_bav <= 1'b0;
              m_k   <= m_k + 8'd1;
              m_cnt <= 3'd2;
              m_st  <= MRLo;
            end else m_cnt <= m_cnt - 3'd1;
          end
          MPost: begin
            if (m_cnt == 3'd0) begin
              m_ready <= 1'b1;
              m_st    <= MIdle;
            end else m_cnt <= m_cnt - 3'd1;
          end
          default: m_st <= MIdle;
        endcase
      end
    end
  end

  // Pulse counters on the selected bridge (never reset).
  int n_we = 0, n_rd = 0, n_wend = 0, n_rend = 0, n_rdy = 0;

  always @(posedge clk) begin
    if (w_we)    n_we   <= n_we + 1;
    if (w_rd)    n_rd   <= n_rd + 1;
    if (w_wend)  n_wend <= n_wend + 1;
    if (w_rend)  n_rend <= n_rend + 1;
    if (w_ready) n_rdy  <= n_rdy + 1;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_bus();
    bus4.rd = 1'b0; bus4.we = 1'b0; bus4.a = '0; bus4.d = '0;
    bus1.rd = 1'b0; bus1.we = 1'b0; bus1.a = '0; bus1.d = '0;
  endtask

  // Present one request for one cycle; returns #1 after the sampling edge.
  task automatic issue(input logic wr, input logic rdq, input logic [23:0] addr,
                       input logic [31:0] data);
    @(posedge clk); #1;
    if (sel) begin
      bus1.we = wr; bus1.rd = rdq; bus1.a = addr; bus1.d = data;
    end else begin
      bus4.we = wr; bus4.rd = rdq; bus4.a = addr; bus4.d = data;
    end
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic wait_ready(input string tag, input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!w_ready && n < max);
    check({tag, " ready seen"}, 32'(w_ready), 32'd1);
  endtask

  int b_we, b_rd, b_wend, b_rend, b_fall, b_rise, b_rdy;
  int n;

  task automatic snap();
    b_we = n_we; b_rd = n_rd; b_wend = n_wend; b_rend = n_rend;
    b_fall = n_fall; b_rise = n_rise; b_rdy = n_rdy;
  endtask

  initial begin
    clear_bus();
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst spo",     w_spo,          32'h0);
    check("rst busy",    32'(w_busy),    32'd0);
    check("rst err",     32'(w_err),     32'd0);
    check("rst ready",   32'(w_ready),   32'd0);
    check("rst mem_a",   32'(w_mema),    32'h0);
    check("rst mem_din", 32'(w_din),     32'h0);
    check("rst mem_we",  32'(w_we),      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Word write, 4 bytes.
    snap();
    issue(1'b1, 1'b0, 24'h000100, 32'hDEADBEEF);
    check("w1 busy",   32'(w_busy), 32'd1);
    check("w1 mem_we", 32'(w_we),   32'd1);
    check("w1 mem_a",  32'(w_mema), 32'h000100);
    check("w1 din0",   32'(w_din),  32'hEF);
    wait_ready("w1", 200, n);
    check("w1 mem_a held", 32'(w_mema), 32'h000100);
    check("w1 we pulses",   n_we - b_we,     1);
    check("w1 wend pulses", n_wend - b_wend, 1);
    check("w1 bytes",       n_fall - b_fall, 4);
    check("w1 err",         32'(w_err),      32'd0);
    check("w1 mem", {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]}, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("w1 busy after",  32'(w_busy),  32'd0);
    check("w1 ready width", 32'(w_ready), 32'd0);

    // Word read of the same location.
    snap();
    issue(1'b0, 1'b1, 24'h000100, 32'h0);
    check("r1 mem_rd", 32'(w_rd),   32'd1);
    check("r1 busy",   32'(w_busy), 32'd1);
    wait_ready("r1", 200, n);
    check("r1 spo",         w_spo,           32'hDEADBEEF);
    check("r1 rd pulses",   n_rd - b_rd,     1);
    check("r1 rend pulses", n_rend - b_rend, 1);
    check("r1 bytes",       n_rise - b_rise, 4);
    check("r1 ctrl idle",   32'(m_ready),    32'd1);

    // rd+we together -> write; a second we while busy is dropped.
    snap();
    issue(1'b1, 1'b1, 24'h000010, 32'h11223344);
    repeat (3) @(posedge clk);
    issue(1'b1, 1'b0, 24'h000020, 32'h55667788);
    wait_ready("rw", 200, n);
    check("rw we pulses", n_we - b_we, 1);
    check("rw rd pulses", n_rd - b_rd, 0);
    check("rw mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h11223344);
    repeat (3) @(posedge clk);

    // Stalled read -> timeout after 64 cycles, then a good read clears err.
    m_stall = 1'b1;
    issue(1'b0, 1'b1, 24'h000100, 32'h0);
    wait_ready("to", 200, n);
    check("to latency", n, 64);
    check("to err",     32'(w_err),  32'd1);
    check("to busy",    32'(w_busy), 32'd0);
    check("to spo",     w_spo,       32'h0);
    @(posedge clk); #1;
    check("to err sticky",  32'(w_err),   32'd1);
    check("to ready width", 32'(w_ready), 32'd0);
    m_stall = 1'b0;
    repeat (3) @(posedge clk);
    issue(1'b0, 1'b1, 24'h000100, 32'h0);
    check("r2 err cleared", 32'(w_err), 32'd0);
    wait_ready("r2", 200, n);
    check("r2 spo", w_spo, 32'hDEADBEEF);
    check("r2 err", 32'(w_err), 32'd0);
    repeat (3) @(posedge clk);

    // Single-byte bridge.
    sel = 1'b1;
    snap();
    issue(1'b1, 1'b0, 24'h000040, 32'h0000005A);
    wait_ready("b1w", 200, n);
    check("b1w bytes", n_fall - b_fall, 1);
    check("b1w mem",   32'(mem[8'h40]), 32'h5A);
    repeat (3) @(posedge clk);
    snap();
    issue(1'b0, 1'b1, 24'h000040, 32'h0);
    wait_ready("b1r", 200, n);
    check("b1r spo",         w_spo,           32'h0000005A);
    check("b1r rend pulses", n_rend - b_rend, 1);
    check("b1r bytes",       n_rise - b_rise, 1);
    repeat (3) @(posedge clk);

    // Reset in the middle of a write stream.
    sel = 1'b0;
    snap();
    issue(1'b1, 1'b0, 24'h000080, 32'hCAFEF00D);
    n = 0;
    while ((n_fall - b_fall) < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid 2 bytes", n_fall - b_fall, 2);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("mid busy",   32'(w_busy),  32'd0);
    check("mid ready",  32'(w_ready), 32'd0);
    check("mid mem_a",  32'(w_mema),  32'h0);
    check("mid din",    32'(w_din),   32'h0);
    check("mid wend",   32'(w_wend),  32'd0);
    check("mid spo",    w_spo,        32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("mid no ready", n_rdy - b_rdy, 0);
    repeat (2) @(posedge clk);
    issue(1'b1, 1'b0, 24'h000080, 32'hCAFEF00D);
    wait_ready("mid w", 200, n);
    check("mid mem", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'hCAFEF00D);
    check("mid err", 32'(w_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
